// File: rtl/rc4_engine.sv
// RC4 decryption engine: key scheduling (INIT + SHUFFLE) followed by PRGA/XOR
// over a ciphertext ROM, with an optional printable-text check that aborts early.
module rc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic                   check_en,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rdata,
  output logic [MSG_AW-1:0]      m_addr,
  input  logic [7:0]             m_rdata,
  output logic [MSG_AW-1:0]      d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_wren
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]     KEY_LAST = KW'(KEY_BYTES - 1);
  localparam logic [MSG_AW-1:0] K_LAST   = MSG_AW'(MSG_LEN - 1);

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    SH_RD_I,
    SH_WAIT_I,
    SH_RD_J,
    SH_WAIT_J,
    SH_WR_I,
    SH_WR_J,
    PR_RD_I,
    PR_WAIT_I,
    PR_RD_J,
    PR_WAIT_J,
    PR_WR_I,
    PR_WR_J,
    PR_RD_F,
    PR_WR_D,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [MSG_AW-1:0]      k_q, k_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             sj_q, sj_d;
  logic [7:0]             m_q, m_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic                   check_q, check_d;
  logic                   pass_q, pass_d;

  logic [7:0] key_arr [KEY_BYTES];
  logic [7:0] key_byte;
  logic [7:0] plain;
  logic       printable;

  // Byte 0 of the key sits in the most significant position.
  for (genvar b = 0; b < KEY_BYTES; b++) begin : g_key
    assign key_arr[b] = key_q[8*(KEY_BYTES-1-b) +: 8];
  end

  assign key_byte  = key_arr[kidx_q];
  assign plain     = s_rdata ^ m_q;
  assign printable = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);
  assign pass      = pass_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      m_q     <= '0;
      key_q   <= '0;
      check_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      m_q     <= m_d;
      key_q   <= key_d;
      check_q <= check_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    m_d     = m_q;
    key_d   = key_q;
    check_d = check_q;
    pass_d  = pass_q;
    busy    = 1'b1;
    done    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wren  = 1'b0;
    m_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    d_wren  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_INIT;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          kidx_d  = '0;
          key_d   = key;
          check_d = check_en;
          pass_d  = 1'b0;
        end
      end
      ST_INIT: begin
        s_addr  = i_q;
        s_wdata = i_q;
        s_wren  = 1'b1;
        i_d     = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = SH_RD_I;
      end
      SH_RD_I: begin
        s_addr  = i_q;
        state_d = SH_WAIT_I;
      end
      SH_WAIT_I: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata + key_byte;
        state_d = SH_RD_J;
      end
      SH_RD_J: begin
        s_addr  = j_q;
        state_d = SH_WAIT_J;
      end
      SH_WAIT_J: begin
        sj_d    = s_rdata;
        state_d = SH_WR_I;
      end
      SH_WR_I: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = SH_WR_J;
      end
      SH_WR_J: begin
        // Written second so that i == j leaves the original value in place.
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        i_d     = i_q + 8'd1;
        kidx_d  = (kidx_q == KEY_LAST) ? '0 : kidx_q + 1'b1;
        if (i_q == 8'hFF) begin
          i_d     = '0;
          j_d     = '0;
          state_d = PR_RD_I;
        end else begin
          state_d = SH_RD_I;
        end
      end
      PR_RD_I: begin
        s_addr  = i_q + 8'd1;
        i_d     = i_q + 8'd1;
        m_addr  = k_q;
        state_d = PR_WAIT_I;
      end
      PR_WAIT_I: begin
        m_addr  = k_q;
        si_d    = s_rdata;
        m_d     = m_rdata;
        j_d     = j_q + s_rdata;
        state_d = PR_RD_J;
      end
      PR_RD_J: begin
        s_addr  = j_q;
        state_d = PR_WAIT_J;
      end
      PR_WAIT_J: begin
        sj_d    = s_rdata;
        state_d = PR_WR_I;
      end
      PR_WR_I: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = PR_WR_J;
      end
      PR_WR_J: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        state_d = PR_RD_F;
      end
      PR_RD_F: begin
        // Post-swap s[i] + s[j] is the same sum as the pre-swap pair.
        s_addr  = si_q + sj_q;
        state_d = PR_WR_D;
      end
      PR_WR_D: begin
        d_addr  = k_q;
        d_wdata = plain;
        d_wren  = 1'b1;
        if (check_q && !printable) begin
          pass_d  = 1'b0;
          state_d = ST_DONE;
        end else if (k_q == K_LAST) begin
          pass_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = PR_RD_I;
        end
      end
      ST_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_engine.sv
// Bench for rc4_engine: two instances ("Key"/9-byte and "Wiki"/5-byte) with
// behavioural S/ROM/D memories and a scoreboard on plaintext writes.
module tb_rc4_engine;

  localparam int W = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  logic [7:0] pt_key  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct_key  [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pt_wiki [5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
  logic [7:0] ct_wiki [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};

  // ---------------- instance A: KEY_BYTES=3, MSG_LEN=9
  logic        a_start, a_check_en, a_busy, a_done, a_pass;
  logic [23:0] a_key;
  logic [7:0]  a_s_addr, a_s_wdata, a_s_rdata, a_m_rdata, a_d_wdata;
  logic        a_s_wren, a_d_wren, a_fill;
  logic [4:0]  a_m_addr, a_d_addr;
  logic [7:0]  a_s_mem [256];
  logic [7:0]  a_m_mem [32];
  logic [7:0]  a_d_mem [32];
  int          a_done_cnt = 0;

  rc4_engine #(.KEY_BYTES(3), .MSG_LEN(9), .MSG_AW(5)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .key(a_key), .check_en(a_check_en),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wren(a_s_wren), .s_rdata(a_s_rdata),
    .m_addr(a_m_addr), .m_rdata(a_m_rdata),
    .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_wren(a_d_wren)
  );

  // ---------------- instance B: KEY_BYTES=4, MSG_LEN=5
  logic        b_start, b_check_en, b_busy, b_done, b_pass;
  logic [31:0] b_key;
  logic [7:0]  b_s_addr, b_s_wdata, b_s_rdata, b_m_rdata, b_d_wdata;
  logic        b_s_wren, b_d_wren, b_fill;
  logic [4:0]  b_m_addr, b_d_addr;
  logic [7:0]  b_s_mem [256];
  logic [7:0]  b_m_mem [32];
  logic [7:0]  b_d_mem [32];
  int          b_done_cnt = 0;

  rc4_engine #(.KEY_BYTES(4), .MSG_LEN(5), .MSG_AW(5)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .key(b_key), .check_en(b_check_en),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wren(b_s_wren), .s_rdata(b_s_rdata),
    .m_addr(b_m_addr), .m_rdata(b_m_rdata),
    .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_wren(b_d_wren)
  );

  // Memory models: registered reads, 1-cycle latency.
  always @(posedge clk) begin
    if (a_s_wren) a_s_mem[a_s_addr] <= a_s_wdata;
    a_s_rdata <= a_s_mem[a_s_addr];
    a_m_rdata <= a_m_mem[a_m_addr];
    if (a_fill) begin
      for (int n = 0; n < 32; n++) a_d_mem[n] <= 8'hFF;
    end else if (a_d_wren) begin
      a_d_mem[a_d_addr] <= a_d_wdata;
    end
    if (b_s_wren) b_s_mem[b_s_addr] <= b_s_wdata;
    b_s_rdata <= b_s_mem[b_s_addr];
    b_m_rdata <= b_m_mem[b_m_addr];
    if (b_fill) begin
      for (int n = 0; n < 32; n++) b_d_mem[n] <= 8'hFF;
    end else if (b_d_wren) begin
      b_d_mem[b_d_addr] <= b_d_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: every plaintext write is popped against the queue.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if (a_d_wren) begin
      chk("a_wren_excl", {31'b0, a_s_wren}, 32'd0);
      if (exp_q_a.size() == 0) chk("a_unexpected_d", 32'd1, 32'd0);
      else begin
        e = exp_q_a.pop_front();
        chk("a_d_write", {19'b0, a_d_addr, a_d_wdata}, {19'b0, e});
      end
    end
    if (b_d_wren) begin
      chk("b_wren_excl", {31'b0, b_s_wren}, 32'd0);
      if (exp_q_b.size() == 0) chk("b_unexpected_d", 32'd1, 32'd0);
      else begin
        e = exp_q_b.pop_front();
        chk("b_d_write", {19'b0, b_d_addr, b_d_wdata}, {19'b0, e});
      end
    end
  end

  task automatic fill_a();
    @(negedge clk); a_fill = 1'b1;
    @(negedge clk); a_fill = 1'b0;
  endtask

  task automatic push_a(input int n);
    for (int q = 0; q < n; q++) exp_q_a.push_back({5'(q), pt_key[q]});
  endtask

  // Runs instance A from one start to done; probe checks S after INIT,
  // noise disturbs start/key/check_en while busy.
  task automatic run_a(input logic [23:0] k, input logic ce, input bit probe,
                       input bit noise, output logic got_pass);
    int cyc;
    bit seen;
    bit ok;
    cyc  = 0;
    seen = 0;
    @(negedge clk);
    a_key = k; a_check_en = ce; a_start = 1'b1;
    while (cyc < 3000 && !seen) begin
      @(negedge clk);
      cyc++;
      if (a_done) begin
        seen     = 1;
        got_pass = a_pass;
        a_start  = 1'b0;
        chk("a_busy_at_done", {31'b0, a_busy}, 32'd0);
      end else if (noise && cyc > 3) begin
        a_start    = ($urandom_range(0, 7) == 0);
        a_check_en = 1'(~ce);
        if (cyc % 64 == 0) a_key = 24'($urandom);
      end else if (cyc >= (noise ? 3 : 1)) begin
        a_start = 1'b0;
      end
      if (probe && cyc == 258) begin
        ok = 1;
        for (int n = 0; n < 256; n++) if (a_s_mem[n] !== 8'(n)) ok = 0;
        chk("a_s_identity_after_init", {31'b0, ok}, 32'd1);
      end
    end
    a_start = 1'b0; a_key = k; a_check_en = ce;
    chk("a_done_seen", {31'b0, seen}, 32'd1);
    if (seen) chk("a_latency_in_bound", {31'b0, (cyc <= 256 + 1536 + 10*9 + 4)}, 32'd1);
  endtask

  task automatic check_d_a(input int n_written);
    for (int q = 0; q < 9; q++)
      chk($sformatf("a_d_mem[%0d]", q), {24'b0, a_d_mem[q]},
          {24'b0, (q < n_written) ? pt_key[q] : 8'hFF});
    chk("a_queue_empty", exp_q_a.size(), 32'd0);
  endtask

  initial begin
    logic p;
    int   dc;
    bit   used [256];
    bit   perm;
    logic [7:0] v;

    reset = 1'b1;
    a_start = 1'b0; a_key = '0; a_check_en = 1'b0; a_fill = 1'b0;
    b_start = 1'b0; b_key = '0; b_check_en = 1'b0; b_fill = 1'b0;
    for (int n = 0; n < 32; n++) begin
      a_m_mem[n] = (n < 9) ? ct_key[n] : 8'h00;
      b_m_mem[n] = (n < 5) ? ct_wiki[n] : 8'h00;
    end
    // Reset with start asserted: reset must win.
    repeat (2) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("rst_a_busy", {31'b0, a_busy}, 32'd0);
    chk("rst_a_done", {31'b0, a_done}, 32'd0);
    chk("rst_a_pass", {31'b0, a_pass}, 32'd0);
    chk("rst_a_wrens", {30'b0, a_s_wren, a_d_wren}, 32'd0);
    chk("rst_a_addrs", {14'b0, a_s_addr, a_m_addr, a_d_addr}, 32'd0);
    chk("rst_b_outs", {27'b0, b_busy, b_done, b_pass, b_s_wren, b_d_wren}, 32'd0);
    chk("rst_b_addrs", {14'b0, b_s_addr, b_m_addr, b_d_addr}, 32'd0);
    reset = 1'b0;

    // 1: "Key" vector, no check, INIT probe, permutation at done.
    fill_a();
    push_a(9);
    dc = a_done_cnt;
    run_a(24'h4B6579, 1'b0, 1'b1, 1'b0, p);
    chk("a_key_pass", {31'b0, p}, 32'd1);
    perm = 1;
    for (int n = 0; n < 256; n++) used[n] = 0;
    for (int n = 0; n < 256; n++) begin
      v = a_s_mem[n];
      if ($isunknown(v) || used[v]) perm = 0; else used[v] = 1;
    end
    chk("a_s_permutation", {31'b0, perm}, 32'd1);
    repeat (3) @(negedge clk);
    chk("a_key_one_done", a_done_cnt - dc, 32'd1);
    check_d_a(9);

    // 2: same with check_en: 'P' fails immediately.
    fill_a();
    push_a(1);
    dc = a_done_cnt;
    run_a(24'h4B6579, 1'b1, 1'b0, 1'b0, p);
    chk("a_abort_pass", {31'b0, p}, 32'd0);
    repeat (3) @(negedge clk);
    chk("a_abort_one_done", a_done_cnt - dc, 32'd1);
    check_d_a(1);

    // 3: reset mid-SHUFFLE, then a clean rerun.
    fill_a();
    dc = a_done_cnt;
    @(negedge clk);
    a_key = 24'h4B6579; a_check_en = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat ($urandom_range(400, 900)) @(negedge clk);
    chk("a_busy_mid_run", {31'b0, a_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("a_busy_after_reset", {31'b0, a_busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("a_no_done_after_abort", a_done_cnt - dc, 32'd0);
    push_a(9);
    run_a(24'h4B6579, 1'b0, 1'b0, 1'b0, p);
    chk("a_rerun_pass", {31'b0, p}, 32'd1);
    repeat (3) @(negedge clk);
    chk("a_rerun_one_done", a_done_cnt - dc, 32'd1);
    check_d_a(9);

    // 4: stray starts, key and check_en changes while busy.
    fill_a();
    push_a(9);
    dc = a_done_cnt;
    run_a(24'h4B6579, 1'b0, 1'b0, 1'b1, p);
    chk("a_noise_pass", {31'b0, p}, 32'd1);
    repeat (3) @(negedge clk);
    chk("a_noise_one_done", a_done_cnt - dc, 32'd1);
    check_d_a(9);

    // 5: "Wiki" vector on instance B with the printable check on.
    @(negedge clk); b_fill = 1'b1;
    @(negedge clk); b_fill = 1'b0;
    for (int q = 0; q < 5; q++) exp_q_b.push_back({5'(q), pt_wiki[q]});
    dc = b_done_cnt;
    b_key = 32'h57696B69; b_check_en = 1'b1; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    begin
      int cyc;
      cyc = 1;
      while (cyc < 3000 && !b_done) begin
        @(negedge clk);
        cyc++;
      end
      chk("b_done_seen", {31'b0, b_done}, 32'd1);
      chk("b_latency_in_bound", {31'b0, (cyc <= 256 + 1536 + 10*5 + 4)}, 32'd1);
      chk("b_pass", {31'b0, b_pass}, 32'd1);
    end
    repeat (3) @(negedge clk);
    chk("b_one_done", b_done_cnt - dc, 32'd1);
    for (int q = 0; q < 5; q++)
      chk($sformatf("b_d_mem[%0d]", q), {24'b0, b_d_mem[q]}, {24'b0, pt_wiki[q]});
    chk("b_queue_empty", exp_q_b.size(), 32'd0);
    chk("b_pass_held", {31'b0, b_pass}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_engine.md
Name: rc4_engine

Overview:
- Parametrised RC4 decryption engine: one start pulse runs the full KSA, shuffle and PRGA/decrypt over a ciphertext ROM.
- Drives an external S working RAM, ciphertext ROM and plaintext RAM.
- Generalises key length and message length.
- Adds an optional plaintext-validity check with early abort and a pass flag, so a key-search top can scan keys.

Parameters:
- KEY_BYTES, 3, key length in bytes (1..32).
- MSG_LEN, 32, message length in bytes (1..256).
- MSG_AW, 5, message address width; 2**MSG_AW >= MSG_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle request pulse; ignored unless idle.
- key  in  8*KEY_BYTES  key; byte k = key[8*(KEY_BYTES-1-k) +: 8], so byte 0 is most significant. Sampled on accepted start.
- check_en  in  1  enables printable-text check; sampled on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at completion or abort.
- pass  out  1  valid with done, held until next accepted start.
- s_addr  out  8  S RAM address.
- s_wdata  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_rdata  in  8  S RAM read data, registered, 1-cycle latency.
- m_addr  out  MSG_AW  ciphertext ROM address.
- m_rdata  in  8  ciphertext ROM data, 1-cycle latency.
- d_addr  out  MSG_AW  plaintext RAM address.
- d_wdata  out  8  plaintext RAM write data.
- d_wren  out  1  plaintext RAM write enable.

Behaviour:
- Reset: state IDLE; i, j, k = 0; all outputs 0, including busy, done, pass, all wren and all addr. RAM contents are not cleared.
- Reset mid-run: abort at the next edge and return to IDLE. No done pulse. S and D contents undefined.
- start coincident with reset: reset wins.
- Arithmetic: all index sums mod 256 (8-bit wrap). Key index is i mod KEY_BYTES, kept as a wrapping counter (no divider).
- INIT: for i = 0..255, write s[i] = i, one write per cycle. Exactly 256 cycles.
- SHUFFLE, i = 0..255, j starts at 0:
  - Read s[i], wait.
  - j = j + s[i] + key[i mod KEY_BYTES].
  - Read s[j], wait.
  - Write s[i] = old s[j], then write s[j] = old s[i].
  - Exactly 6 cycles per i. i == j is legal; the final value equals the original.
- PRGA, k = 0..MSG_LEN-1; i and j reset to 0 on PRGA entry:
  - i = i + 1; read s[i]; j = j + s[i]; read s[j]; swap as in SHUFFLE.
  - Read s[(s[i] + s[j]) mod 256], using post-swap values, to get f.
  - Read m[k] (may overlap the S reads).
  - Write d[k] = f ^ m[k] (one d_wren cycle).
  - At most 10 cycles per byte.
- Check (check_en = 1): a byte passes iff it is 0x61..0x7A or 0x20.
  - On the first failing byte: write it to D, then pulse done with pass = 0 and return to IDLE.
- Completion: after d[MSG_LEN-1] is written, pulse done for one cycle and return to IDLE.
  - pass = 1 if check_en = 0 or all bytes passed.
  - busy falls in the same cycle done rises.
- Total latency from accepted start to done, with no abort: at most 256 + 1536 + 10*MSG_LEN + 4 cycles.
- start, key or check_en changes while busy: ignored.
- start high for several cycles: only the first idle-cycle pulse is accepted. A start coincident with done is ignored.
- Write enables:
  - s_wren and d_wren are never asserted in IDLE.
  - s_wren and d_wren are never both high in a single cycle.

Test Plan:
- KEY_BYTES=3, MSG_LEN=9, key 0x4B6579 ("Key"), m = BB F3 16 E8 D9 40 AF 0A D3, check_en=0 -> D = 50 6C 61 69 6E 74 65 78 74 ("Plaintext"); done once; pass=1; latency within bound.
- Same run with check_en=1 -> d[0]=0x50 written; done after the first byte with pass=0; d[1..8] untouched (preload 0xFF, still 0xFF).
- KEY_BYTES=4, MSG_LEN=5, key 0x57696B69 ("Wiki"), m = 10 21 BF 04 20, check_en=1 -> D = 70 65 64 69 61 ("pedia"); pass=1.
- After INIT phase (probe the S model at cycle 256 after start) -> s[n]=n for all n; S model is a permutation at done.
- Reset asserted mid-SHUFFLE, then a fresh start -> no done from the aborted run; second run reproduces the "Key" vector exactly.
- start pulses while busy and key changed mid-run -> ignored; result matches the originally sampled key; exactly one done per accepted start.
